// File: rtl/ram_fifo_pkg.sv
// Shared types and width helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic {
    WRITE  = 1'b0,
    REFILL = 1'b1
  } mode_e;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM pointer: counts 0..DEPTH-1 and returns to 0, independent of powers of two.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int PW = ptr_w(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO over a single-port sync-write/async-read RAM with a registered head word.
// Optional occupancy output enabled by defining RAM_FIFO_LEVEL_EN.
//
//   mode   | meaning
//   WRITE  | head register loaded or RAM empty; accept pushes, RAM addressed by wr_ptr
//   REFILL | head empty but RAM holds words; read rd_ptr into the head, stall input
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       ram_we,
  output logic [$clog2(DEPTH)-1:0]   ram_a,
  output logic [WIDTH-1:0]           ram_wd,
  input  logic [WIDTH-1:0]           ram_rd
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+2)-1:0] level
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    ram_cnt_nxt;
  logic             out_valid_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             wr_inc;
  logic             rd_inc;
  mode_e            mode;

  always_comb begin
    mode = (!out_valid && (ram_cnt != '0)) ? REFILL : WRITE;
  end

  always_comb begin
    in_ready      = 1'b0;
    ram_we        = 1'b0;
    ram_a         = wr_ptr;
    push          = 1'b0;
    pop           = 1'b0;
    bypass        = 1'b0;
    wr_inc        = 1'b0;
    rd_inc        = 1'b0;
    ram_cnt_nxt   = ram_cnt;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    case (mode)
      REFILL: begin
        ram_a         = rd_ptr;
        rd_inc        = 1'b1;
        ram_cnt_nxt   = ram_cnt - 1'b1;
        out_valid_nxt = 1'b1;
        out_data_nxt  = ram_rd;
      end
      default: begin
        // in_ready depends on registered state only, so out_ready never reaches it
        in_ready = !rst && ((ram_cnt < CW'(DEPTH)) || ((ram_cnt == '0) && !out_valid));
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        bypass   = push && (ram_cnt == '0) && (!out_valid || pop);
        if (bypass) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = in_data;
        end else begin
          if (pop) begin
            out_valid_nxt = 1'b0;
          end
          if (push) begin
            ram_we      = 1'b1;
            wr_inc      = 1'b1;
            ram_cnt_nxt = ram_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  assign ram_wd = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      ram_cnt   <= ram_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  ram_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (wr_inc),
    .ptr (wr_ptr)
  );

  ram_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (rd_inc),
    .ptr (rd_ptr)
  );

`ifdef RAM_FIFO_LEVEL_EN
  localparam int LW = $clog2(DEPTH + 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= LW'(ram_cnt_nxt) + LW'(out_valid_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (DEPTH=8, WIDTH=32) with an attached RAM model.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CAP   = DEPTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ram_we;
  logic [2:0]       ram_a;
  logic [WIDTH-1:0] ram_wd;
  logic [WIDTH-1:0] ram_rd;
`ifdef RAM_FIFO_LEVEL_EN
  logic [3:0]       level;
`endif

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] mem [DEPTH];
  int wr_cnt, rd_cnt, wr_wraps, rd_wraps, n_push;
  logic last_ov;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_wd;
  assign ram_rd = mem[ram_a];

  ram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_wd    (ram_wd),
    .ram_rd    (ram_rd)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_level();
`ifdef RAM_FIFO_LEVEL_EN
    chk("level", 32'(level), 32'(q.size()));
`endif
  endtask

  // One clock: drive inputs, judge the cycle at the falling edge, commit to the model after the rise.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy);
    logic push, pop, ov, exp_we;
    int   ram_words;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    ov        = out_valid;
    last_ov   = ov;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    ram_words = q.size() - (ov ? 1 : 0);
    if (!ov && ram_words > 0) begin
      chk("refill_in_ready", 32'(in_ready), 32'(0));
      chk("refill_we", 32'(ram_we), 32'(0));
      chk("refill_addr", 32'(ram_a), 32'(rd_cnt % DEPTH));
      if (ram_a == 3'd7) rd_wraps++;
      rd_cnt++;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(ram_words < DEPTH));
      exp_we = push && !(ram_words == 0 && (!ov || pop));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      if (exp_we) begin
        chk("wr_addr", 32'(ram_a), 32'(wr_cnt % DEPTH));
        chk("wr_data", ram_wd, id);
        if (ram_a == 3'd7) wr_wraps++;
        wr_cnt++;
      end
    end
    if (q.size() == 0) chk("empty_no_valid", 32'(out_valid), 32'(0));
    if (q.size() == CAP) chk("full_no_ready", 32'(in_ready), 32'(0));
    if (pop) begin
      if (q.size() > 0) chk("order", out_data, q[0]);
      else chk("pop_while_empty", 32'(pop), 32'(0));
    end
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (push) begin
      q.push_back(id);
      n_push++;
    end
    chk_level();
  endtask

  task automatic model_reset();
    q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    n_push = 0;
  endtask

  initial begin
    int k, sent, prev, n;
    logic iv, ordy;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    model_reset();
    wr_wraps  = 0;
    rd_wraps  = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_level();
    chk("idle_in_ready", 32'(in_ready), 32'(1));

    // bypass into empty FIFO
    cycle(1'b1, 32'h0000_000A, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'(1));
    chk("t1_out_data", out_data, 32'hA);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_drained", 32'(out_valid), 32'(0));

    // fill to capacity
    n_push = 0;
    for (int i = 1; i <= CAP; i++) cycle(1'b1, 32'(i), 1'b0);
    chk("t2_pushes", 32'(n_push), 32'(CAP));
    chk("t2_head", out_data, 32'h1);
    chk("t2_full_in_ready", 32'(in_ready), 32'(0));
`ifdef RAM_FIFO_LEVEL_EN
    chk("t2_level", 32'(level), 32'(9));
`endif

    // drain with refill bubbles
    k = 0;
    while (q.size() > 0 && k < 40) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("t3_alternate", 32'(last_ov), 32'(k % 2 == 0));
      k++;
    end
    chk("t3_drain_len", 32'(k), 32'(2 * CAP - 1));
    chk("t3_empty", 32'(out_valid), 32'(0));

    // simultaneous pop+push with empty RAM
    cycle(1'b1, 32'h5, 1'b0);
    cycle(1'b1, 32'h6, 1'b1);
    chk("t5_out_data", out_data, 32'h6);
    chk("t5_out_valid", 32'(out_valid), 32'(1));
    cycle(1'b0, 32'h0, 1'b1);

    // random traffic with wraps
    wr_wraps = 0;
    rd_wraps = 0;
    sent = 0;
    n = 0;
    while ((sent < 30 || q.size() > 0) && n < 600) begin
      iv   = (sent < 30) && ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) == 0);
      prev = n_push;
      cycle(iv, $urandom, ordy);
      sent += n_push - prev;
      n++;
    end
    chk("t4_finished", 32'(n < 600), 32'(1));
    chk("t4_wr_wraps", 32'(wr_wraps >= 2), 32'(1));
    chk("t4_rd_wraps", 32'(rd_wraps >= 2), 32'(1));

    // reset mid-operation
    for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(32'h100 + i), 1'b0);
`ifdef RAM_FIFO_LEVEL_EN
    chk("t6_level5", 32'(level), 32'(5));
`endif
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'(0));
    chk("t6_in_ready", 32'(in_ready), 32'(0));
    chk("t6_ram_we", 32'(ram_we), 32'(0));
    model_reset();
    chk_level();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h7, 1'b0);
    chk("t6_out_valid_after", 32'(out_valid), 32'(1));
    chk("t6_out_data_after", out_data, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
